// File: rtl/pipe_hazard_ctrl.sv
// Hazard sequencer for the five-stage LC-3b pipeline: drives latch load/flush
// enables, the PC redirect select, and saturating stall/flush counters.
module pipe_hazard_ctrl #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             imem_req,
   input  logic             imem_resp,
   input  logic             dmem_req,
   input  logic             dmem_resp,
   input  logic             idex_mem_read,
   input  logic [2:0]       idex_dest,
   input  logic             idex_dest_valid,
   input  logic [2:0]       ifid_sr1,
   input  logic             ifid_sr1_valid,
   input  logic [2:0]       ifid_sr2,
   input  logic             ifid_sr2_valid,
   input  logic             branch_taken,
   output logic             load_pc,
   output logic             load_ifid,
   output logic             load_idex,
   output logic             load_exmem,
   output logic             load_memwb,
   output logic             flush_ifid,
   output logic             flush_idex,
   output logic             flush_exmem,
   output logic             pc_redirect,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   // StDiscard: a redirect happened while a fetch was outstanding; the word
   // returned by that fetch belongs to the wrong path and must be dropped.
   typedef enum logic {StRun, StDiscard} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic dstall, istall, load_use;
   logic ld_pc, ld_ifid, ld_idex, ld_exmem, ld_memwb;
   logic fl_ifid, fl_idex, fl_exmem, redirect;

   assign dstall   = dmem_req & ~dmem_resp;
   assign istall   = imem_req & ~imem_resp;
   assign load_use = idex_mem_read & idex_dest_valid &
                     ((ifid_sr1_valid & (ifid_sr1 == idex_dest)) |
                      (ifid_sr2_valid & (ifid_sr2 == idex_dest)));

   // Prioritised latch control and next state.
   always_comb begin
      ld_pc    = 1'b0;
      ld_ifid  = 1'b0;
      ld_idex  = 1'b0;
      ld_exmem = 1'b0;
      ld_memwb = 1'b0;
      fl_ifid  = 1'b0;
      fl_idex  = 1'b0;
      fl_exmem = 1'b0;
      redirect = 1'b0;
      state_d  = state_q;
      if (dstall) begin
         // whole pipe frozen
      end else if (branch_taken) begin
         ld_pc    = 1'b1;
         redirect = 1'b1;
         ld_ifid  = 1'b1;
         ld_idex  = 1'b1;
         ld_exmem = 1'b1;
         ld_memwb = 1'b1;
         fl_ifid  = 1'b1;
         fl_idex  = 1'b1;
         fl_exmem = 1'b1;
         state_d  = istall ? StDiscard : StRun;
      end else if (state_q == StDiscard) begin
         // IF/ID stays flushed even on the cycle the stale word arrives
         ld_pc    = imem_resp;
         ld_ifid  = 1'b1;
         fl_ifid  = 1'b1;
         ld_idex  = 1'b1;
         fl_idex  = 1'b1;
         ld_exmem = 1'b1;
         ld_memwb = 1'b1;
         if (imem_resp) state_d = StRun;
      end else if (load_use) begin
         ld_idex  = 1'b1;
         fl_idex  = 1'b1;
         ld_exmem = 1'b1;
         ld_memwb = 1'b1;
      end else if (istall) begin
         ld_ifid  = 1'b1;
         fl_ifid  = 1'b1;
         ld_idex  = 1'b1;
         ld_exmem = 1'b1;
         ld_memwb = 1'b1;
      end else begin
         ld_pc    = 1'b1;
         ld_ifid  = 1'b1;
         ld_idex  = 1'b1;
         ld_exmem = 1'b1;
         ld_memwb = 1'b1;
      end
   end

   // Saturating performance counter next values.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!ld_pc && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (redirect && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   // State and counter registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StRun;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // Controls are forced inactive for as long as reset is held low.
   assign load_pc     = reset & ld_pc;
   assign load_ifid   = reset & ld_ifid;
   assign load_idex   = reset & ld_idex;
   assign load_exmem  = reset & ld_exmem;
   assign load_memwb  = reset & ld_memwb;
   assign flush_ifid  = reset & fl_ifid;
   assign flush_idex  = reset & fl_idex;
   assign flush_exmem = reset & fl_exmem;
   assign pc_redirect = reset & redirect;
   assign stall_count = stall_cnt_q;
   assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (4-bit counters so saturation is reachable).
module tb_pipe_hazard_ctrl;

   localparam int unsigned CNT_W = 4;
   localparam int          CMAX  = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic reset;
   logic imem_req, imem_resp, dmem_req, dmem_resp;
   logic idex_mem_read, idex_dest_valid, ifid_sr1_valid, ifid_sr2_valid, branch_taken;
   logic [2:0] idex_dest, ifid_sr1, ifid_sr2;
   logic load_pc, load_ifid, load_idex, load_exmem, load_memwb;
   logic flush_ifid, flush_idex, flush_exmem, pc_redirect;
   logic [CNT_W-1:0] stall_count, flush_count;
   logic [8:0] out_vec;

   pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_resp(imem_resp),
      .dmem_req(dmem_req), .dmem_resp(dmem_resp),
      .idex_mem_read(idex_mem_read), .idex_dest(idex_dest),
      .idex_dest_valid(idex_dest_valid),
      .ifid_sr1(ifid_sr1), .ifid_sr1_valid(ifid_sr1_valid),
      .ifid_sr2(ifid_sr2), .ifid_sr2_valid(ifid_sr2_valid),
      .branch_taken(branch_taken),
      .load_pc(load_pc), .load_ifid(load_ifid), .load_idex(load_idex),
      .load_exmem(load_exmem), .load_memwb(load_memwb),
      .flush_ifid(flush_ifid), .flush_idex(flush_idex), .flush_exmem(flush_exmem),
      .pc_redirect(pc_redirect),
      .stall_count(stall_count), .flush_count(flush_count)
   );

   always #5 clk = ~clk;

   // {load_pc, load_ifid, load_idex, load_exmem, load_memwb,
   //  flush_ifid, flush_idex, flush_exmem, pc_redirect}
   assign out_vec = {load_pc, load_ifid, load_idex, load_exmem, load_memwb,
                     flush_ifid, flush_idex, flush_exmem, pc_redirect};

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   bit m_disc;
   int m_stall, m_flush;

   typedef struct {
      logic dreq, dresp, ireq, iresp, br, mr, dv;
      logic [2:0] dest;
      logic s1v;
      logic [2:0] sr1;
      logic s2v;
      logic [2:0] sr2;
      logic [8:0] exp;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic dreq, logic dresp, logic ireq, logic iresp, logic br,
                               logic mr, logic dv, logic [2:0] dest, logic s1v,
                               logic [2:0] sr1, logic s2v, logic [2:0] sr2, logic [8:0] exp);
      vec_t v;
      v.dreq = dreq; v.dresp = dresp; v.ireq = ireq; v.iresp = iresp; v.br = br;
      v.mr = mr; v.dv = dv; v.dest = dest; v.s1v = s1v; v.sr1 = sr1;
      v.s2v = s2v; v.sr2 = sr2; v.exp = exp;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Expected controls straight from the priority rules.
   function automatic logic [8:0] model_out();
      bit dstall = dmem_req && !dmem_resp;
      bit istall = imem_req && !imem_resp;
      bit hazard = idex_mem_read && idex_dest_valid &&
                   ((ifid_sr1_valid && ifid_sr1 == idex_dest) ||
                    (ifid_sr2_valid && ifid_sr2 == idex_dest));
      if (!reset || dstall) return 9'b0;
      if (branch_taken)     return 9'b11111_111_1;
      if (m_disc)           return {imem_resp, 4'b1111, 4'b1100};
      if (hazard)           return 9'b00111_010_0;
      if (istall)           return 9'b01111_100_0;
      return 9'b11111_000_0;
   endfunction

   task automatic model_reset();
      m_disc = 0; m_stall = 0; m_flush = 0;
   endtask

   task automatic model_step();
      logic [8:0] e = model_out();
      bit dstall = dmem_req && !dmem_resp;
      if (!reset) return;
      if (!e[8] && m_stall < CMAX) m_stall++;
      if (e[0] && m_flush < CMAX) m_flush++;
      if (!dstall) begin
         if (branch_taken) m_disc = imem_req && !imem_resp;
         else if (m_disc && imem_resp) m_disc = 0;
      end
   endtask

   // One clock cycle: compare at the falling edge, advance the model, leave at posedge+1.
   task automatic cycle(input string nm);
      @(negedge clk);
      chk({nm, "_ctl"}, {23'b0, out_vec}, {23'b0, model_out()});
      chk({nm, "_stall_cnt"}, {28'b0, stall_count}, m_stall);
      chk({nm, "_flush_cnt"}, {28'b0, flush_count}, m_flush);
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_now(input string nm, input logic [8:0] e);
      #1;
      chk(nm, {23'b0, out_vec}, {23'b0, e});
   endtask

   task automatic idle_inputs();
      imem_req = 0; imem_resp = 1; dmem_req = 0; dmem_resp = 0;
      idex_mem_read = 0; idex_dest = 0; idex_dest_valid = 0;
      ifid_sr1 = 0; ifid_sr1_valid = 0; ifid_sr2 = 0; ifid_sr2_valid = 0;
      branch_taken = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 0;
      model_reset();
      #1;
      chk("rst_ctl", {23'b0, out_vec}, 32'h0);
      @(posedge clk);
      #1;
      reset = 1;
   endtask

   initial begin
      idle_inputs();
      imem_resp = 0;
      reset = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("reset_ctl", {23'b0, out_vec}, 32'h0);
      chk("reset_stall_cnt", {28'b0, stall_count}, 0);
      chk("reset_flush_cnt", {28'b0, flush_count}, 0);
      reset = 1;
      imem_resp = 1;

      // No hazards
      for (int i = 0; i < 5; i++) begin
         expect_now("idle_ctl", 9'b11111_000_0);
         cycle("idle");
      end
      chk("idle_stall_cnt", {28'b0, stall_count}, 0);

      // LDR R2 in EX, ADD R3,R2,R1 in ID
      do_reset();
      idex_mem_read = 1; idex_dest = 2; idex_dest_valid = 1;
      ifid_sr1 = 2; ifid_sr1_valid = 1; ifid_sr2 = 1; ifid_sr2_valid = 1;
      expect_now("lu_bubble", 9'b00111_010_0);
      cycle("lu");
      idle_inputs();
      expect_now("lu_after", 9'b11111_000_0);
      cycle("lu_after");
      chk("lu_stall_cnt", {28'b0, stall_count}, 1);

      // Data cache miss for 4 cycles
      do_reset();
      dmem_req = 1; dmem_resp = 0;
      for (int i = 0; i < 4; i++) begin
         expect_now("dstall_frozen", 9'b0);
         cycle("dstall");
      end
      dmem_resp = 1;
      expect_now("dstall_done", 9'b11111_000_0);
      cycle("dstall_done");
      chk("dstall_stall_cnt", {28'b0, stall_count}, 4);

      // Taken branch with fetch in flight; response two cycles later
      do_reset();
      imem_req = 1; imem_resp = 0; branch_taken = 1;
      expect_now("br_redirect", 9'b11111_111_1);
      cycle("br");
      branch_taken = 0;
      for (int i = 0; i < 2; i++) begin
         expect_now("br_discard", 9'b01111_110_0);
         cycle("br_disc");
      end
      imem_resp = 1;
      expect_now("br_drop_word", 9'b11111_110_0);
      cycle("br_drop");
      imem_req = 0;
      expect_now("br_run", 9'b11111_000_0);
      cycle("br_run");
      chk("br_flush_cnt", {28'b0, flush_count}, 1);
      chk("br_stall_cnt", {28'b0, stall_count}, 2);

      // Single-cycle priority table, all starting and ending in RUN
      do_reset();
      vecs.push_back(mk(0,0,0,1,0, 0,0,0, 0,0, 0,0, 9'b11111_000_0));
      vecs.push_back(mk(0,0,0,1,0, 1,1,2, 1,2, 0,0, 9'b00111_010_0));
      vecs.push_back(mk(0,0,0,1,0, 1,1,5, 0,5, 1,5, 9'b00111_010_0));
      vecs.push_back(mk(0,0,0,1,0, 1,0,2, 1,2, 0,0, 9'b11111_000_0));
      vecs.push_back(mk(0,0,0,1,0, 0,1,2, 1,2, 0,0, 9'b11111_000_0));
      vecs.push_back(mk(0,0,0,1,0, 1,1,2, 0,2, 1,3, 9'b11111_000_0));
      vecs.push_back(mk(1,0,0,1,0, 0,0,0, 0,0, 0,0, 9'b00000_000_0));
      vecs.push_back(mk(1,1,0,1,0, 0,0,0, 0,0, 0,0, 9'b11111_000_0));
      vecs.push_back(mk(0,0,1,0,0, 0,0,0, 0,0, 0,0, 9'b01111_100_0));
      vecs.push_back(mk(0,0,0,1,1, 1,1,2, 1,2, 0,0, 9'b11111_111_1));
      vecs.push_back(mk(1,0,0,1,1, 0,0,0, 0,0, 0,0, 9'b00000_000_0));
      vecs.push_back(mk(0,0,1,0,0, 1,1,4, 1,4, 0,0, 9'b00111_010_0));
      vecs.push_back(mk(0,0,1,1,1, 0,0,0, 0,0, 0,0, 9'b11111_111_1));
      vecs.push_back(mk(1,0,1,0,0, 1,1,2, 1,2, 0,0, 9'b00000_000_0));
      for (int i = 0; i < vecs.size(); i++) begin
         dmem_req = vecs[i].dreq; dmem_resp = vecs[i].dresp;
         imem_req = vecs[i].ireq; imem_resp = vecs[i].iresp;
         branch_taken = vecs[i].br; idex_mem_read = vecs[i].mr;
         idex_dest_valid = vecs[i].dv; idex_dest = vecs[i].dest;
         ifid_sr1_valid = vecs[i].s1v; ifid_sr1 = vecs[i].sr1;
         ifid_sr2_valid = vecs[i].s2v; ifid_sr2 = vecs[i].sr2;
         expect_now($sformatf("table%0d", i), vecs[i].exp);
         cycle($sformatf("table%0d", i));
      end

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         dmem_req = ($urandom_range(0, 3) == 0);
         dmem_resp = $urandom_range(0, 1);
         imem_req = $urandom_range(0, 1);
         imem_resp = $urandom_range(0, 1);
         branch_taken = ($urandom_range(0, 5) == 0);
         idex_mem_read = $urandom_range(0, 1);
         idex_dest_valid = $urandom_range(0, 1);
         idex_dest = 3'($urandom_range(0, 3));
         ifid_sr1_valid = $urandom_range(0, 1);
         ifid_sr1 = 3'($urandom_range(0, 3));
         ifid_sr2_valid = $urandom_range(0, 1);
         ifid_sr2 = 3'($urandom_range(0, 3));
         cycle("rand");
      end

      // Stall counter saturation
      do_reset();
      dmem_req = 1; dmem_resp = 0;
      for (int i = 0; i < (1 << CNT_W) + 5; i++) cycle("sat");
      chk("sat_stall_cnt", {28'b0, stall_count}, CMAX);

      // Asynchronous reset while in DISCARD
      idle_inputs();
      imem_req = 1; imem_resp = 0; branch_taken = 1;
      cycle("ar_br");
      branch_taken = 0;
      cycle("ar_disc");
      #1;
      reset = 0;
      model_reset();
      #1;
      chk("ar_ctl", {23'b0, out_vec}, 32'h0);
      chk("ar_stall_cnt", {28'b0, stall_count}, 0);
      chk("ar_flush_cnt", {28'b0, flush_count}, 0);
      @(posedge clk);
      #1;
      reset = 1;
      expect_now("ar_run_istall", 9'b01111_100_0);
      cycle("ar_after");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
